// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath default widths and load funct3 encodings.
package cpu_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int CNT_W_DEF      = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB boundary bundle: MEM-stage fields, hazard controls and registered WB outputs.
// Handshake: no valid/ready backpressure; mem_valid qualifies the MEM fields each cycle,
// stall holds the WB register, flush squashes it, and wb_valid qualifies the WB fields.
interface mem_wb_stage_if
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
);
    logic                  mem_valid;
    logic [DATA_W-1:0]     mem_alu_out;
    logic [DATA_W-1:0]     mem_rdata;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_RegWrite;
    logic                  mem_MemtoReg;
    logic [2:0]            mem_funct3;
    logic                  stall;
    logic                  flush;

    logic                  wb_valid;
    logic [DATA_W-1:0]     wb_ALU_out;
    logic [DATA_W-1:0]     wb_datamem_out;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_RegWrite;
    logic                  wb_MemtoReg;
    logic                  wb_misalign;
    logic [CNT_W-1:0]      retired_cnt;

    modport master (
        output mem_valid, mem_alu_out, mem_rdata, mem_rd, mem_RegWrite,
               mem_MemtoReg, mem_funct3, stall, flush,
        input  wb_valid, wb_ALU_out, wb_datamem_out, wb_rd, wb_RegWrite,
               wb_MemtoReg, wb_misalign, retired_cnt
    );

    modport slave (
        input  mem_valid, mem_alu_out, mem_rdata, mem_rd, mem_RegWrite,
               mem_MemtoReg, mem_funct3, stall, flush,
        output wb_valid, wb_ALU_out, wb_datamem_out, wb_rd, wb_RegWrite,
               wb_MemtoReg, wb_misalign, retired_cnt
    );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of a little-endian
// word, extends it by load type, and flags misaligned halfword/word loads.
module load_align
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  logic [2:0]        funct3_i,
    input  logic              is_load_i,
    output logic [DATA_W-1:0] data_o,
    output logic              misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select and extension by load type; unknown funct3 passes the word through.
    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];
        data_o   = rdata_i;
        case (funct3_i)
            F3_LB:   data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_LH:   data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

    // Misalignment only matters for loads: odd halfword address or non-word-aligned LW.
    always_comb begin
        misalign_o = 1'b0;
        if (is_load_i) begin
            case (funct3_i)
                F3_LH, F3_LHU: misalign_o = offset_i[0];
                F3_LW:         misalign_o = (offset_i != 2'b00);
                default:       misalign_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment, misalign squash and retired-instruction count.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);

    logic [DATA_W-1:0] align_data;
    logic              align_misalign;

    load_align #(.DATA_W(DATA_W)) u_align (
        .rdata_i    (bus.mem_rdata),
        .offset_i   (bus.mem_alu_out[1:0]),
        .funct3_i   (bus.mem_funct3),
        .is_load_i  (bus.mem_MemtoReg),
        .data_o     (align_data),
        .misalign_o (align_misalign)
    );

    logic                  valid_q,    valid_d;
    logic [DATA_W-1:0]     alu_q,      alu_d;
    logic [DATA_W-1:0]     dmem_q,     dmem_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memtoreg_q, memtoreg_d;
    logic                  misalign_q, misalign_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    // Next state: flush squashes, stall holds, otherwise capture the MEM fields.
    always_comb begin
        valid_d    = valid_q;
        alu_d      = alu_q;
        dmem_d     = dmem_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        if (bus.flush) begin
            valid_d    = 1'b0;
            alu_d      = '0;
            dmem_d     = '0;
            rd_d       = '0;
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            misalign_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d    = bus.mem_valid;
            alu_d      = bus.mem_alu_out;
            dmem_d     = align_data;
            rd_d       = bus.mem_rd;
            memtoreg_d = bus.mem_MemtoReg;
            // A misaligned load never writes back and never retires.
            regwrite_d = bus.mem_RegWrite & bus.mem_valid & ~align_misalign;
            misalign_d = align_misalign & bus.mem_valid;
            if (bus.mem_valid && !align_misalign) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // WB register bank and counter; reset clears immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            alu_q      <= '0;
            dmem_q     <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            alu_q      <= alu_d;
            dmem_q     <= dmem_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.wb_valid       = valid_q;
    assign bus.wb_ALU_out     = alu_q;
    assign bus.wb_datamem_out = dmem_q;
    assign bus.wb_rd          = rd_q;
    assign bus.wb_RegWrite    = regwrite_q;
    assign bus.wb_MemtoReg    = memtoreg_q;
    assign bus.wb_misalign    = misalign_q;
    assign bus.retired_cnt    = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases from the load/misalign/hazard rules plus random
// traffic, checked against a reference model of what the WB register should hold.
module tb_mem_wb_stage;

    logic clk;
    logic rst_n;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference model of WB register contents
    logic        m_valid;
    logic [31:0] m_alu;
    logic [31:0] m_dmem;
    logic [4:0]  m_rd;
    logic        m_rw;
    logic        m_m2r;
    logic        m_mis;
    logic [31:0] m_cnt;

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input int unsigned off,
                                             input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b + 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h + 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic exp_mis(input int unsigned off, input logic [2:0] f3, input logic m2r);
        if (!m2r) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
        if (f3 == 3'd2) return off != 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_alu = 0; m_dmem = 0; m_rd = 0;
        m_rw = 0; m_m2r = 0; m_mis = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        n_cmp++; assert (bus.wb_valid === m_valid) else begin n_err++;
            $error("FAIL %s wb_valid got %0h exp %0h", tag, bus.wb_valid, m_valid); end
        n_cmp++; assert (bus.wb_ALU_out === m_alu) else begin n_err++;
            $error("FAIL %s wb_ALU_out got %08h exp %08h", tag, bus.wb_ALU_out, m_alu); end
        n_cmp++; assert (bus.wb_datamem_out === m_dmem) else begin n_err++;
            $error("FAIL %s wb_datamem_out got %08h exp %08h", tag, bus.wb_datamem_out, m_dmem); end
        n_cmp++; assert (bus.wb_rd === m_rd) else begin n_err++;
            $error("FAIL %s wb_rd got %0d exp %0d", tag, bus.wb_rd, m_rd); end
        n_cmp++; assert (bus.wb_RegWrite === m_rw) else begin n_err++;
            $error("FAIL %s wb_RegWrite got %0h exp %0h", tag, bus.wb_RegWrite, m_rw); end
        n_cmp++; assert (bus.wb_MemtoReg === m_m2r) else begin n_err++;
            $error("FAIL %s wb_MemtoReg got %0h exp %0h", tag, bus.wb_MemtoReg, m_m2r); end
        n_cmp++; assert (bus.wb_misalign === m_mis) else begin n_err++;
            $error("FAIL %s wb_misalign got %0h exp %0h", tag, bus.wb_misalign, m_mis); end
        n_cmp++; assert (bus.retired_cnt === m_cnt) else begin n_err++;
            $error("FAIL %s retired_cnt got %08h exp %08h", tag, bus.retired_cnt, m_cnt); end
    endtask

    // Driver: apply one cycle of MEM inputs, clock it, update the model, check 1ns later.
    task automatic step(input string tag, input logic v, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                        input logic m2r, input logic [2:0] f3, input logic st, input logic fl);
        logic mis;
        bus.mem_valid    = v;
        bus.mem_alu_out  = alu;
        bus.mem_rdata    = rdata;
        bus.mem_rd       = rd;
        bus.mem_RegWrite = rw;
        bus.mem_MemtoReg = m2r;
        bus.mem_funct3   = f3;
        bus.stall        = st;
        bus.flush        = fl;
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_alu = 0; m_dmem = 0; m_rd = 0; m_rw = 0; m_m2r = 0; m_mis = 0;
        end else if (!st) begin
            mis     = exp_mis(int'(alu % 4), f3, m2r);
            m_valid = v;
            m_alu   = alu;
            m_dmem  = exp_load(rdata, int'(alu % 4), f3);
            m_rd    = rd;
            m_m2r   = m2r;
            m_rw    = rw && v && !mis;
            m_mis   = mis && v;
            if (v && !mis) m_cnt = m_cnt + 1;
        end
        #1;
        check_all(tag);
    endtask

    localparam logic [31:0] RD_PAT = 32'h80F17F02;

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        bus.mem_valid = 0; bus.mem_alu_out = 0; bus.mem_rdata = 0; bus.mem_rd = 0;
        bus.mem_RegWrite = 0; bus.mem_MemtoReg = 0; bus.mem_funct3 = 0;
        bus.stall = 0; bus.flush = 0;

        #2;
        check_all("reset_init");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Load extension on 0x80F17F02
        step("lb_off3",  1, 32'h1000_0003, RD_PAT, 5'd1, 1, 1, 3'b000, 0, 0);
        step("lbu_off3", 1, 32'h1000_0003, RD_PAT, 5'd2, 1, 1, 3'b100, 0, 0);
        step("lhu_off2", 1, 32'h1000_0002, RD_PAT, 5'd3, 1, 1, 3'b101, 0, 0);
        step("lh_off0",  1, 32'h1000_0000, RD_PAT, 5'd4, 1, 1, 3'b001, 0, 0);
        step("lh_off2",  1, 32'h1000_0002, RD_PAT, 5'd4, 1, 1, 3'b001, 0, 0);
        step("lb_off1",  1, 32'h1000_0001, RD_PAT, 5'd5, 1, 1, 3'b000, 0, 0);

        // Misaligned loads and an unusual funct3
        step("lw_off2_mis",  1, 32'h2000_0002, RD_PAT, 5'd6, 1, 1, 3'b010, 0, 0);
        step("lhu_off1_mis", 1, 32'h2000_0001, RD_PAT, 5'd6, 1, 1, 3'b101, 0, 0);
        step("lw_off0",      1, 32'h2000_0000, RD_PAT, 5'd6, 1, 1, 3'b010, 0, 0);
        step("f3_7_off3",    1, 32'h2000_0003, RD_PAT, 5'd8, 1, 1, 3'b111, 0, 0);
        step("alu_lw_off3",  1, 32'h2000_0003, RD_PAT, 5'd9, 1, 0, 3'b010, 0, 0);

        // Stall holds, then stall+flush squashes
        step("cap_1234", 1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd7, 1, 0, 3'b010, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1, $urandom, $urandom, 5'($urandom_range(0, 31)), 1, 1,
                 3'($urandom_range(0, 7)), 1, 0);
        end
        step("stall_flush", 1, 32'h5555_0000, 32'h1, 5'd9, 1, 0, 3'b010, 1, 1);

        // Bubble with RegWrite set
        step("bubble", 0, 32'h0000_0040, RD_PAT, 5'd10, 1, 0, 3'b010, 0, 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", $urandom_range(0, 3) != 0, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset mid-cycle with the pipeline full
        step("pre_reset_full", 1, 32'hCAFE_0000, RD_PAT, 5'd31, 1, 1, 3'b010, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap: preload near the top, then three retiring captures
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        step("wrap_ffffffff", 1, 32'h0000_0100, RD_PAT, 5'd1, 1, 0, 3'b010, 0, 0);
        step("wrap_00000000", 1, 32'h0000_0104, RD_PAT, 5'd2, 1, 1, 3'b010, 0, 0);
        step("wrap_00000001", 1, 32'h0000_0108, RD_PAT, 5'd3, 1, 1, 3'b000, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register for the five-stage pipeline. Sits directly upstream of the write-back MemtoReg select.
- Captures the MEM-stage ALU result, data-memory read word and write-back control each cycle.
- Aligns and sign/zero-extends load data, detects misaligned loads, and counts retired instructions.
- Outputs feed the write-back select and the register file write port.

Parameters:
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register index width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_valid  input  1  MEM stage holds a real instruction
- mem_alu_out  input  DATA_W  ALU result / effective address from MEM
- mem_rdata  input  DATA_W  raw word read from data memory (word-aligned)
- mem_rd  input  REG_ADDR_W  destination register
- mem_RegWrite  input  1  instruction writes the register file
- mem_MemtoReg  input  1  instruction is a load
- mem_funct3  input  3  load type
- stall  input  1  hold the WB register contents
- flush  input  1  squash the WB register contents
- wb_valid  output  1  WB stage holds a real instruction
- wb_ALU_out  output  DATA_W  registered ALU result
- wb_datamem_out  output  DATA_W  registered aligned/extended load data
- wb_rd  output  REG_ADDR_W  registered destination
- wb_RegWrite  output  1  register-file write enable; gated by valid and misalign
- wb_MemtoReg  output  1  registered write-back select
- wb_misalign  output  1  registered misaligned-load flag
- retired_cnt  output  CNT_W  count of instructions captured into WB

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, including retired_cnt. Deassertion takes effect at the next rising edge.
- Update priority per edge: flush > stall > capture.
- Flush: wb_valid, wb_RegWrite and wb_misalign go to 0. Data and rd fields go to 0. retired_cnt holds.
- Stall (no flush): all registers hold, including retired_cnt.
- Capture: every registered field takes its MEM input on the edge.
  - wb_valid = mem_valid.
  - wb_RegWrite = mem_RegWrite & mem_valid & ~misalign.
- Latency: exactly 1 cycle from MEM inputs to wb_* outputs. No combinational path from inputs to outputs.
- Load alignment: combinational, on mem_rdata. Byte offset = mem_alu_out[1:0], little-endian.
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: halfword at offset[1]*16, sign-extended.
  - 101 LHU: halfword at offset[1]*16, zero-extended.
  - 010 LW: full word.
  - Any other funct3: full word, no flag.
- Misalign is computed only when mem_MemtoReg=1:
  - LH/LHU with offset[0]=1 is misaligned.
  - LW with offset≠0 is misaligned.
  - When mem_MemtoReg=0, misalign=0.
- wb_misalign = misalign & mem_valid, captured with the other fields.
- wb_datamem_out is captured whether or not MemtoReg=1. It is don't-care for non-loads but must still be deterministic per the rules above.
- retired_cnt increments by 1 on each capture edge where mem_valid=1 and misalign=0. It wraps modulo 2^CNT_W.
- Simultaneous stall and flush: flush wins.
- Reset mid-operation: the state clears immediately, without waiting for a clock edge.

Decomposition:
- Shared package cpu_pkg, holding:
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - The DATA_W and REG_ADDR_W defaults.
- One combinational sub-module, load_align. It takes rdata, offset and funct3, and produces aligned data and the misalign flag.
- The registers and counter live in mem_wb_stage.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with the pipeline full → all wb_* outputs and retired_cnt read 0 before the next edge.
- Load extension: mem_rdata=0x80F17F02, funct3=LB, offset=3 → wb_datamem_out=0xFFFFFF80 after 1 cycle. With LBU, offset=3 → 0x00000080. With LHU, offset=2 → 0x000080F1. With LH, offset=0 → 0x00007F02.
- Misalign: LW, offset=2, RegWrite=1, valid=1 → wb_misalign=1, wb_RegWrite=0, retired_cnt unchanged. LB, offset=1 → no flag.
- Stall/flush: capture ALU=0x1234, rd=7, then stall 3 cycles with changing inputs → outputs hold 0x1234/7. Then stall and flush together → wb_valid=0, wb_RegWrite=0.
- Bubble: mem_valid=0, mem_RegWrite=1 → wb_RegWrite=0, wb_valid=0, counter holds.
- Counter wrap: preload to 0xFFFFFFFE via a force or back-to-back captures, then apply 3 valid captures → retired_cnt sequence FFFFFFFF, 00000000, 00000001.
